// File: rtl/rvb_xperm_seq_if.sv
// ----------------------------------------------------------------------------
// rvb_xperm_seq_if
// Handshake bundle between the issue/writeback logic and the sequential
// crossbar-permutation unit.
//   in_valid/in_ready : request handshake (mode, rs1, rs2 qualify in_valid)
//   flush             : synchronous abort from the pipeline
//   res_valid/res_ready: result handshake, res qualified by res_valid
// master = issue/writeback side, slave = permutation unit.
// ----------------------------------------------------------------------------
interface rvb_xperm_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      mode;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res;

    modport master (
        output in_valid, mode, rs1, rs2, flush, res_ready,
        input  in_ready, res_valid, res
    );

    modport slave (
        input  in_valid, mode, rs1, rs2, flush, res_ready,
        output in_ready, res_valid, res
    );
endinterface

// File: rtl/rvb_xperm_seq.sv
// ----------------------------------------------------------------------------
// rvb_xperm_seq
// Multi-cycle xperm4 / xperm8 / xperm16 (and xperm32 when XLEN=64) unit.
// Each RUN cycle resolves LANES result elements: element i of the result is
// the rs1 element selected by the i-th rs2 element, or zero when that index
// is not below the element count N.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   io     : rvb_xperm_seq_if.slave
//            in_valid/in_ready, mode, rs1, rs2 - request side
//            flush                             - abort in-flight/pending op
//            res_valid/res_ready, res          - result side
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module rvb_xperm_seq #(
    parameter int XLEN  = 32,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            reset,
    rvb_xperm_seq_if.slave  io
);
    localparam int SH_W  = $clog2(XLEN);
    // Counter must hold N + LANES - 1 without wrapping (N <= XLEN/4).
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [1:0]        mode_q, mode_d;

    logic [2:0]        lg_sz;
    logic [CNT_W-1:0]  n_elem;
    logic [CNT_W-1:0]  cnt_next;
    logic              reserved;
    logic              last_step;

    // Resolve one result element e into acc. Element size is 1 << (mode+2)
    // bits. Elements at or beyond N are left untouched. The whole sz-bit
    // index is compared against N so high index bits force a zero result.
    function automatic logic [XLEN-1:0] write_elem(
        input logic [XLEN-1:0]  acc,
        input logic [XLEN-1:0]  tbl,
        input logic [XLEN-1:0]  idxv,
        input logic [1:0]       m,
        input logic [CNT_W-1:0] e
    );
        logic [2:0]       lg;
        logic [CNT_W-1:0] n;
        logic [XLEN-1:0]  mask;
        logic [XLEN-1:0]  idx;
        logic [XLEN-1:0]  val;
        logic [SH_W-1:0]  dst_sh;
        logic [SH_W-1:0]  src_sh;
        lg         = {1'b0, m} + 3'd2;
        n          = CNT_W'(XLEN >> lg);
        mask       = ~({XLEN{1'b1}} << (8'd1 << lg));
        write_elem = acc;
        if (e < n) begin
            dst_sh = SH_W'(e) << lg;
            idx    = (idxv >> dst_sh) & mask;
            if (idx < XLEN'(n)) begin
                src_sh = SH_W'(idx) << lg;
                val    = (tbl >> src_sh) & mask;
            end else begin
                val = '0;
            end
            write_elem = (acc & ~(mask << dst_sh)) | (val << dst_sh);
        end
    endfunction

    always_comb begin
        lg_sz     = {1'b0, mode_q} + 3'd2;
        // Reserved word mode at XLEN=32 yields N=1, i.e. a single RUN cycle.
        n_elem    = CNT_W'(XLEN >> lg_sz);
        reserved  = (XLEN == 32) && (mode_q == 2'b11);
        cnt_next  = cnt_q + CNT_W'(LANES);
        last_step = (cnt_next >= n_elem);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        in_ready_d  = in_ready_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        mode_d      = mode_q;

        if (io.flush) begin
            // Abort: result register is deliberately left as is.
            state_d     = IDLE;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        rs1_d      = io.rs1;
                        rs2_d      = io.rs2;
                        mode_d     = io.mode;
                        res_d      = '0;
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (!reserved) begin
                        for (int l = 0; l < LANES; l++) begin
                            res_d = write_elem(res_d, rs1_q, rs2_q, mode_q,
                                               cnt_q + CNT_W'(l));
                        end
                    end
                    cnt_d = cnt_next;
                    if (last_step) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    if (io.res_ready) begin
                        state_d     = IDLE;
                        res_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    // Control and result state; reset dominates flush and both handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Captured operands: only meaningful between acceptance and DONE.
    always_ff @(posedge clk) begin
        rs1_q  <= rs1_d;
        rs2_q  <= rs2_d;
        mode_q <= mode_d;
    end

    assign io.in_ready  = in_ready_q;
    assign io.res_valid = res_valid_q;
    assign io.res       = res_q;
endmodule

// File: tb/tb_rvb_xperm_seq.sv
module tb_rvb_xperm_seq;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_en;

    typedef struct {
        logic [63:0] res;
        int          c;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    rvb_xperm_seq_if #(.XLEN(32)) ifa ();
    rvb_xperm_seq_if #(.XLEN(64)) ifb ();

    rvb_xperm_seq #(.XLEN(32), .LANES(4)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .io    (ifa)
    );

    rvb_xperm_seq #(.XLEN(64), .LANES(1)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .io    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain element-wise table lookup.
    function automatic logic [63:0] model(input int xlen, input logic [63:0] a,
                                          input logic [63:0] b, input int m);
        int          sz;
        int          n;
        logic [63:0] mask;
        logic [63:0] idx;
        logic [63:0] r;
        sz = 4 << m;
        n  = xlen / sz;
        r  = 64'd0;
        if (xlen == 32 && m == 3) return 64'd0;
        mask = (64'd1 << sz) - 64'd1;
        for (int i = 0; i < n; i++) begin
            idx = (b >> (i * sz)) & mask;
            if (idx < 64'(n)) r = r | (((a >> (idx * 64'(sz))) & mask) << (i * sz));
        end
        return r;
    endfunction

    function automatic int exp_c(input int xlen, input int lanes, input int m);
        int n;
        if (xlen == 32 && m == 3) return 1;
        n = xlen / (4 << m);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic logic [63:0] gen_idx(input int xlen, input int m);
        int          sz;
        int          n;
        logic [63:0] mask;
        logic [63:0] el;
        logic [63:0] r;
        sz   = 4 << m;
        n    = xlen / sz;
        mask = (64'd1 << sz) - 64'd1;
        r    = 64'd0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) el = {$urandom, $urandom} & mask;
            else                           el = 64'($urandom_range(0, n));
            r = r | (el << (i * sz));
        end
        return r;
    endfunction

    function automatic logic rdy(input int inst);
        return (inst == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    function automatic logic vld(input int inst);
        return (inst == 0) ? ifa.res_valid : ifb.res_valid;
    endfunction

    task automatic set_req(input int inst, input logic v, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [1:0] m);
        if (inst == 0) begin
            ifa.in_valid = v; ifa.rs1 = r1[31:0]; ifa.rs2 = r2[31:0]; ifa.mode = m;
        end else begin
            ifb.in_valid = v; ifb.rs1 = r1; ifb.rs2 = r2; ifb.mode = m;
        end
    endtask

    task automatic set_rr(input int inst, input logic v);
        if (inst == 0) ifa.res_ready = v;
        else           ifb.res_ready = v;
    endtask

    task automatic issue(input int inst, input logic [63:0] r1, input logic [63:0] r2,
                         input logic [1:0] m, input logic [63:0] exp_res, input int c);
        int   t;
        exp_t e;
        t = 0;
        set_req(inst, 1'b1, r1, r2, m);
        while (!rdy(inst) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("accept_ready", 64'(rdy(inst)), 64'd1);
        if (rdy(inst)) begin
            @(posedge clk); #1;
            e.res = exp_res; e.c = c; e.acc = cyc;
            if (inst == 0) qa.push_back(e);
            else           qb.push_back(e);
        end
        // Operands are don't-care after acceptance.
        set_req(inst, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_valid(input int inst);
        int t;
        t = 0;
        while (t < 100) begin
            chk("in_ready_busy", 64'(rdy(inst)), 64'd0);
            @(posedge clk); #1; t++;
            if (vld(inst)) break;
        end
        chk("res_valid_seen", 64'(vld(inst)), 64'd1);
    endtask

    task automatic run_op(input int inst, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [1:0] m, input logic [63:0] exp_res, input int c,
                          input int stall);
        issue(inst, r1, r2, m, exp_res, c);
        wait_valid(inst);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(vld(inst)), 64'd1);
            chk("stall_in_ready", 64'(rdy(inst)), 64'd0);
        end
        set_rr(inst, 1'b1);
        @(posedge clk); #1;
        set_rr(inst, 1'b0);
        chk("res_valid_clear", 64'(vld(inst)), 64'd0);
    endtask

    initial begin : mon_a
        logic        pv;
        logic [63:0] lr;
        exp_t        e;
        pv = 1'b0; lr = 64'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ifa.res_valid && !pv) begin
                    if (qa.size() == 0) chk("res_valid_unexpected_a", 64'(ifa.res_valid), 64'd0);
                    else begin
                        e = qa.pop_front();
                        chk("res_a", 64'(ifa.res), e.res);
                        chk("latency_a", 64'(cyc - e.acc), 64'(e.c));
                    end
                end else if (ifa.res_valid && pv) begin
                    chk("res_stable_a", 64'(ifa.res), lr);
                end
                if (ifa.res_valid) chk("in_ready_done_a", 64'(ifa.in_ready), 64'd0);
            end
            pv = ifa.res_valid;
            lr = 64'(ifa.res);
        end
    end

    initial begin : mon_b
        logic        pv;
        logic [63:0] lr;
        exp_t        e;
        pv = 1'b0; lr = 64'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ifb.res_valid && !pv) begin
                    if (qb.size() == 0) chk("res_valid_unexpected_b", 64'(ifb.res_valid), 64'd0);
                    else begin
                        e = qb.pop_front();
                        chk("res_b", ifb.res, e.res);
                        chk("latency_b", 64'(cyc - e.acc), 64'(e.c));
                    end
                end else if (ifb.res_valid && pv) begin
                    chk("res_stable_b", ifb.res, lr);
                end
                if (ifb.res_valid) chk("in_ready_done_b", 64'(ifb.in_ready), 64'd0);
            end
            pv = ifb.res_valid;
            lr = ifb.res;
        end
    end

    initial begin : stim
        logic [63:0] r1;
        logic [63:0] r2;
        int          m;
        checks = 0; errors = 0; mon_en = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        set_req(0, 1'b0, 64'd0, 64'd0, 2'd0);
        set_req(1, 1'b0, 64'd0, 64'd0, 2'd0);
        ifa.flush = 1'b0; ifb.flush = 1'b0;
        ifa.res_ready = 1'b0; ifb.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        chk("rst_in_ready_a", 64'(ifa.in_ready), 64'd1);
        chk("rst_valid_a", 64'(ifa.res_valid), 64'd0);
        chk("rst_res_a", 64'(ifa.res), 64'd0);
        chk("rst_in_ready_b", 64'(ifb.in_ready), 64'd1);
        chk("rst_valid_b", 64'(ifb.res_valid), 64'd0);
        chk("rst_res_b", ifb.res, 64'd0);
        mon_en = 1'b1;

        // Directed cases, XLEN=32 LANES=4.
        run_op(0, 64'h76543210, 64'h01234567, 2'd0, 64'h01234567, 2, 0);
        run_op(0, 64'h44332211, 64'h00010203, 2'd1, 64'h11223344, 1, 5);
        run_op(0, 64'h44332211, 64'h04FF0100, 2'd1, 64'h00002211, 1, 0);
        run_op(0, 64'hBEEFCAFE, 64'h00000001, 2'd2, 64'hCAFEBEEF, 1, 1);
        run_op(0, 64'hDEADBEEF, 64'h00000000, 2'd3, 64'h0, 1, 0);

        // Flush on the first RUN edge of a nibble op.
        issue(0, 64'h76543210, 64'h01234567, 2'd0, 64'h01234567, 2);
        ifa.flush = 1'b1;
        @(posedge clk); #1;
        ifa.flush = 1'b0;
        qa.delete(qa.size() - 1);
        chk("flush_valid", 64'(ifa.res_valid), 64'd0);
        chk("flush_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("flush_res", 64'(ifa.res), 64'd0);
        // A request presented together with flush must be ignored.
        set_req(0, 1'b1, 64'h12345678, 64'h0, 2'd1);
        ifa.flush = 1'b1;
        @(posedge clk); #1;
        ifa.flush = 1'b0;
        set_req(0, 1'b0, 64'h0, 64'h0, 2'd0);
        chk("flush_blocks_accept", 64'(ifa.in_ready), 64'd1);
        run_op(0, 64'h44332211, 64'h00010203, 2'd1, 64'h11223344, 1, 0);

        // Reset while holding a result in DONE.
        issue(0, 64'h44332211, 64'h00010203, 2'd1, 64'h11223344, 1);
        wait_valid(0);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk("done_rst_res", 64'(ifa.res), 64'd0);
        chk("done_rst_valid", 64'(ifa.res_valid), 64'd0);
        chk("done_rst_in_ready", 64'(ifa.in_ready), 64'd1);

        // Random, all modes, XLEN=32.
        for (int k = 0; k < 40; k++) begin
            m  = $urandom_range(0, 3);
            r1 = {32'd0, $urandom};
            r2 = gen_idx(32, m) & 64'hFFFF_FFFF;
            if (m == 3) r2 = {32'd0, $urandom};
            run_op(0, r1, r2, 2'(m), model(32, r1, r2, m), exp_c(32, 4, m),
                   $urandom_range(0, 2));
        end

        // XLEN=64, LANES=1.
        run_op(1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2'd0,
               64'h0123456789ABCDEF, 16, 0);
        for (int k = 0; k < 20; k++) begin
            m  = $urandom_range(0, 3);
            r1 = {$urandom, $urandom};
            r2 = gen_idx(64, m);
            run_op(1, r1, r2, 2'(m), model(64, r1, r2, m), exp_c(64, 1, m),
                   $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pending_a", 64'(qa.size()), 64'd0);
        chk("pending_b", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
